// File: rtl/requant_scheduler_pkg.sv
// Shared constants and helpers for the requantization scheduler.
package requant_scheduler_pkg;

  localparam int unsigned NReqDef = 4;
  localparam int unsigned DwDef   = 16;
  localparam int unsigned ShiftW  = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_shift_unit.sv
// Combinational arithmetic right shift with round-to-nearest, ties-to-even.
module round_shift_unit
  import requant_scheduler_pkg::*;
#(
  parameter int unsigned DW = DwDef
) (
  input  logic signed [DW-1:0]     data_in,
  input  logic        [ShiftW-1:0] shift,
  output logic signed [DW-1:0]     data_out
);

  logic signed [DW-1:0] shifted;
  logic        [DW-1:0] mask;
  logic        [DW-1:0] rem;
  logic        [DW-1:0] half;
  logic                 round_up;

  always_comb begin
    shifted  = data_in >>> shift;
    mask     = ~({DW{1'b1}} << shift);
    rem      = $unsigned(data_in) & mask;
    half     = (shift == '0) ? '0 : (DW'(1) << (shift - ShiftW'(1)));
    // Dropped bits above half round up; exactly half rounds toward the even quotient.
    round_up = (shift != '0) && ((rem > half) || ((rem == half) && shifted[0]));
    data_out = shifted + $signed({{(DW-1){1'b0}}, round_up});
  end

endmodule

// File: rtl/requant_scheduler.sv
// Round-robin scheduler feeding N_REQ accumulators through one two-stage rounding-shift pipeline.
module requant_scheduler
  import requant_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDef,
  parameter int unsigned DW    = DwDef
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [id_width(N_REQ)-1:0]    cfg_idx,
  input  logic [ShiftW-1:0]             cfg_shift,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DW-1:0]           req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          out_valid,
  output logic [DW-1:0]                 out_data,
  output logic [id_width(N_REQ)-1:0]    out_id,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int unsigned IdW = id_width(N_REQ);

  logic [ShiftW-1:0] shift_q [N_REQ];
  logic [IdW-1:0]    ptr_q;
  logic [DW-1:0]     data_arr [N_REQ];

  logic              s1_valid_q;
  logic [DW-1:0]     s1_data_q;
  logic [IdW-1:0]    s1_id_q;
  logic [ShiftW-1:0] s1_shift_q;

  logic              s2_valid_q;
  logic [DW-1:0]     s2_data_q;
  logic [IdW-1:0]    s2_id_q;

  logic              gnt_found;
  logic [IdW-1:0]    gnt_idx;
  logic              s2_adv;
  logic              s1_adv;
  logic              accept;
  logic [DW-1:0]     rounded;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  // Search starts at the pointer, wrapping once around all requesters.
  always_comb begin
    int unsigned cand;
    logic [IdW-1:0] cand_id;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_id = IdW'(cand);
      if (!gnt_found && req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_id;
      end
    end
  end

  always_comb begin
    s2_adv    = !s2_valid_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    // Reset gates the handshake directly so no request is accepted while rst_n is low.
    accept    = rst_n && gnt_found && s1_adv;
    req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    out_valid = s2_valid_q;
    out_data  = s2_data_q;
    out_id    = s2_id_q;
    busy      = s1_valid_q || s2_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        shift_q[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_idx) < N_REQ)) begin
      shift_q[cfg_idx] <= cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
    end
  end

  // Stage 1 samples the pre-write shift, so a same-cycle cfg write affects only later accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s1_shift_q <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q  <= data_arr[gnt_idx];
        s1_id_q    <= gnt_idx;
        s1_shift_q <= shift_q[gnt_idx];
      end
    end
  end

  round_shift_unit #(
    .DW (DW)
  ) u_round_shift_unit (
    .data_in  (s1_data_q),
    .shift    (s1_shift_q),
    .data_out (rounded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= rounded;
        s2_id_q   <= s1_id_q;
      end
    end
  end

endmodule

// File: tb/tb_requant_scheduler.sv
// Directed bench for requant_scheduler with a queue-based reference model checked every cycle.
module tb_requant_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [3:0]    cfg_shift;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;
  logic          out_ready;
  logic          busy;

  requant_scheduler #(
    .N_REQ (N),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_shift (cfg_shift),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int id;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   got_d[$];
  int   got_id[$];
  int   got_cyc[$];
  int   got_lat[$];
  int   mshift[N];
  int   rr;
  int   cyc;
  int   n_acc;
  int   n_out;
  int   n_outv;
  int   total;
  int   bad;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference rounding via integer floor division, remainder compared with half the divisor.
  function automatic int mround(input int d, input int s);
    int p, fl, r;
    p  = 1 << s;
    fl = d / p;
    if ((d % p != 0) && (d < 0)) fl = fl - 1;
    r = d - fl * p;
    if ((2 * r > p) || ((2 * r == p) && (fl % 2 != 0))) fl = fl + 1;
    return fl;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_busy", busy, 0);
      q.delete();
      for (int i = 0; i < N; i++) mshift[i] = 0;
      rr = 0;
    end else begin
      chk("busy", busy, (q.size() != 0) ? 1 : 0);
      if (out_valid) begin
        n_outv++;
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          chk("out_data", $signed(out_data), q[0].d);
          chk("out_id", out_id, q[0].id);
          if (out_ready) begin
            got_d.push_back(q[0].d);
            got_id.push_back(q[0].id);
            got_cyc.push_back(cyc);
            got_lat.push_back(cyc - q[0].cyc);
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (req_ready != 0) begin
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(rr + k) % N]) w = (rr + k) % N;
        end
        if (w < 0) begin
          chk("ready_without_valid", req_ready, 0);
        end else begin
          chk("grant_onehot", req_ready, 1 << w);
          q.push_back('{d: mround(int'($signed(req_data[w*DW +: DW])), mshift[w]), id: w,
                        cyc: cyc});
          rr = (w + 1) % N;
          n_acc++;
        end
      end
      if (cfg_we) mshift[cfg_idx] = int'(cfg_shift);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input int idx, input int sh);
    cfg_we    = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_shift = 4'(sh);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input int i, input int d);
    bit ok;
    ok = 0;
    req_valid[i] = 1'b1;
    req_data[i*DW +: DW] = 16'(d);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      if (q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int base, a0, o0, hd, hid, v0;
    int exp31[6];
    int exp32[6];
    exp31 = '{2, 2, 2, -2, -2, -2};
    exp32 = '{0, 1, 2, 3, 0, 1};
    total = 0; bad = 0; cyc = 0; n_acc = 0; n_out = 0; n_outv = 0; rr = 0;
    cfg_we = 0; cfg_idx = 0; cfg_shift = 0;
    req_valid = '0; req_data = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    req_valid = '1;
    #2;
    chk("por_req_ready", req_ready, 0);
    chk("por_out_valid", out_valid, 0);
    chk("por_busy", busy, 0);
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Tie rounding with shift 2.
    cfg(0, 2);
    base = got_d.size();
    send(0, 6); send(0, 10); send(0, 7); send(0, -6); send(0, -10); send(0, -7);
    drain();
    for (int k = 0; k < 6; k++) chk($sformatf("round_tie_%0d", k), got_d[base + k], exp31[k]);

    // Round-robin sequence and throughput from reset.
    do_reset();
    base = got_d.size();
    a0 = n_acc;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(100 + i);
    req_valid = '1;
    for (int t = 0; t < 50; t++) begin
      if (n_acc - a0 >= 6) break;
      tick();
    end
    req_valid = '0;
    chk("rr_accept_count", n_acc - a0, 6);
    drain();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_id_%0d", k), got_id[base + k], exp32[k]);
      chk($sformatf("rr_lat_%0d", k), got_lat[base + k], 2);
      if (k > 0) chk($sformatf("rr_gap_%0d", k), got_cyc[base + k] - got_cyc[base + k - 1], 1);
    end

    // Backpressure with full pipeline.
    a0 = n_acc;
    o0 = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(-300 + 37 * i);
    req_valid = '1;
    repeat (4) tick();
    @(negedge clk);
    hd = out_data;
    hid = out_id;
    for (int t = 0; t < 3; t++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data_hold", out_data, hd);
      chk("bp_id_hold", out_id, hid);
      chk("bp_ready_zero", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    out_ready = 1'b1;
    drain();
    chk("bp_accepts", n_acc - a0, 2);
    chk("bp_no_loss", n_out - o0, n_acc - a0);

    // Config write coinciding with accept uses the old shift.
    cfg(1, 1);
    base = got_d.size();
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_shift = 4'd3;
    req_valid[1] = 1'b1;
    req_data[1*DW +: DW] = 16'd64;
    @(negedge clk);
    chk("cfg_same_cycle_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    req_valid[1] = 1'b0;
    send(1, 64);
    drain();
    chk("cfg_old_shift", got_d[base], 32);
    chk("cfg_new_shift", got_d[base + 1], 8);

    // Shift of zero passes the most negative value.
    cfg(2, 0);
    base = got_d.size();
    send(2, -32768);
    drain();
    chk("shift0_min", got_d[base], -32768);

    // Reset with two results in flight.
    out_ready = 1'b0;
    send(0, 5);
    send(1, 7);
    chk("pre_rst_busy", busy, 1);
    req_valid[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    v0 = n_outv;
    repeat (5) tick();
    chk("post_rst_no_output", n_outv - v0, 0);
    base = got_d.size();
    send(3, 9);
    drain();
    chk("post_rst_result", got_d[base], 9);
    chk("post_rst_id", got_id[base], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
